// File: rtl/lcd_bus_if.sv
// 4-bit HD44780-style character-LCD bus as seen at the panel pins.
interface lcd_bus_if;
  logic [3:0] SF_D;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;

  modport master (output SF_D, LCD_E, LCD_RS, LCD_RW);
  modport slave  (input  SF_D, LCD_E, LCD_RS, LCD_RW);
endinterface

// File: rtl/lcd_bus_monitor.sv
// Passive monitor for the 4-bit character-LCD bus: follows the init nibble
// sequence, reassembles bytes, tracks the DDRAM address and flags E-width,
// nibble-gap, busy-time and read-strobe violations.
module lcd_bus_monitor #(
  parameter int MIN_E_HIGH = 12,
  parameter int GAP_NIB    = 50,
  parameter int BUSY_CMD   = 2000,
  parameter int BUSY_CLR   = 82000
) (
  input  logic           clk,
  input  logic           rst_n,
  lcd_bus_if.slave       bus,
  output logic           init_done,
  output logic           byte_valid,
  output logic           byte_rs,
  output logic [7:0]     byte_data,
  output logic [6:0]     ddram_addr,
  output logic           err_timing,
  output logic           err_busy,
  output logic           err_read
);

  typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, HI, LO} state_t;

  state_t      state_q, state_d;
  logic        e_s1, e_s2, e_s3;
  logic [3:0]  d_s1, d_s2;
  logic        rs_s1, rs_s2, rw_s1, rw_s2;
  logic        rise, fall;
  logic [15:0] eh_cnt;
  logic [17:0] gap_cnt;
  logic        rd_flag;
  // event stage: captured in the fall-detect cycle, consumed one cycle later
  logic        ev_q, rs_q, short_q;
  logic [3:0]  nib_q;
  logic [17:0] gap_q;
  logic [3:0]  hi_nib;
  logic        hi_rs;
  logic [17:0] busy_req;
  logic        hi_ld, emit, set_tim, set_busy, set_init;
  logic [7:0]  byte_new;
  logic [6:0]  addr_d;

  assign rise     = e_s2 & ~e_s3;
  assign fall     = ~e_s2 & e_s3;
  assign byte_new = {hi_nib, nib_q};

  // two-flop synchronizers for every bus input, plus an E delay for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {e_s1, e_s2, e_s3} <= '0;
      {d_s1, d_s2}       <= '0;
      {rs_s1, rs_s2}     <= '0;
      {rw_s1, rw_s2}     <= '0;
    end else begin
      e_s1  <= bus.LCD_E;  e_s2  <= e_s1;  e_s3 <= e_s2;
      d_s1  <= bus.SF_D;   d_s2  <= d_s1;
      rs_s1 <= bus.LCD_RS; rs_s2 <= rs_s1;
      rw_s1 <= bus.LCD_RW; rw_s2 <= rw_s1;
    end
  end

  // E-high and fall-to-fall counters, read-strobe tracking, event capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eh_cnt  <= '0;
      gap_cnt <= '0;
      rd_flag <= 1'b0;
      err_read <= 1'b0;
      ev_q    <= 1'b0;
      rs_q    <= 1'b0;
      short_q <= 1'b0;
      nib_q   <= '0;
      gap_q   <= '0;
    end else begin
      if (e_s2) eh_cnt <= (eh_cnt == '1) ? eh_cnt : eh_cnt + 16'd1;
      else      eh_cnt <= '0;
      if (fall)                gap_cnt <= '0;
      else if (gap_cnt != '1)  gap_cnt <= gap_cnt + 18'd1;
      if (rise) rd_flag <= rw_s2;
      if (rise && rw_s2) err_read <= 1'b1;
      // a read strobe is dropped entirely; only its fall still restarts the gap
      ev_q <= fall & ~rd_flag;
      if (fall) begin
        nib_q   <= d_s2;
        rs_q    <= rs_s2;
        short_q <= (eh_cnt < 16'(MIN_E_HIGH));
        gap_q   <= gap_cnt;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT0;
    else        state_q <= state_d;
  end

  // next state and per-event strobes
  always_comb begin
    state_d  = state_q;
    hi_ld    = 1'b0;
    emit     = 1'b0;
    set_tim  = ev_q & short_q;
    set_busy = 1'b0;
    set_init = 1'b0;
    if (ev_q) begin
      case (state_q)
        INIT0: state_d = (!rs_q && nib_q == 4'h3) ? INIT1 : INIT0;
        INIT1: state_d = (!rs_q && nib_q == 4'h3) ? INIT2 : INIT0;
        INIT2: state_d = (!rs_q && nib_q == 4'h3) ? INIT3 : INIT0;
        INIT3: begin
          if (!rs_q && nib_q == 4'h2) begin
            state_d  = HI;
            set_init = 1'b1;
          end else begin
            state_d = (nib_q == 4'h3) ? INIT1 : INIT0;
          end
        end
        HI: begin
          hi_ld    = 1'b1;
          set_busy = (gap_q < busy_req);
          state_d  = LO;
        end
        LO: begin
          emit    = 1'b1;
          set_tim = short_q | (gap_q < 18'(GAP_NIB)) | (rs_q != hi_rs);
          state_d = HI;
        end
        default: state_d = INIT0;
      endcase
    end
  end

  // DDRAM address that the byte being emitted will leave behind
  always_comb begin
    addr_d = ddram_addr;
    if (!hi_rs) begin
      if (byte_new[7])                          addr_d = byte_new[6:0];
      else if (byte_new inside {8'h01, 8'h02, 8'h03}) addr_d = '0;
    end else begin
      if (ddram_addr == 7'h27)      addr_d = 7'h40;
      else if (ddram_addr == 7'h67) addr_d = 7'h00;
      else                          addr_d = ddram_addr + 7'd1;
    end
  end

  // byte assembly, address/busy tracking and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_nib     <= '0;
      hi_rs      <= 1'b0;
      byte_valid <= 1'b0;
      byte_rs    <= 1'b0;
      byte_data  <= '0;
      ddram_addr <= '0;
      busy_req   <= 18'(BUSY_CMD);
      init_done  <= 1'b0;
      err_timing <= 1'b0;
      err_busy   <= 1'b0;
    end else begin
      if (hi_ld) begin
        hi_nib <= nib_q;
        hi_rs  <= rs_q;
      end
      byte_valid <= emit;
      if (emit) begin
        byte_data  <= byte_new;
        byte_rs    <= hi_rs;
        ddram_addr <= addr_d;
        busy_req   <= (!hi_rs && byte_new inside {8'h01, 8'h02, 8'h03}) ?
                      18'(BUSY_CLR) : 18'(BUSY_CMD);
      end
      if (set_init) init_done  <= 1'b1;
      if (set_tim)  err_timing <= 1'b1;
      if (set_busy) err_busy   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor. The clear/home busy time is scaled to
// 8200 cycles so the whole run stays short; the stimulus gaps scale with it.
module tb_lcd_bus_monitor;
  localparam int BUSY_CLR_TB = 8200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done, byte_valid, byte_rs, err_timing, err_busy, err_read;
  logic [7:0] byte_data;
  logic [6:0] ddram_addr;
  int         checks = 0;
  int         errors = 0;
  int         bv_cnt = 0;

  lcd_bus_if bus ();

  lcd_bus_monitor #(.BUSY_CLR(BUSY_CLR_TB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .init_done(init_done), .byte_valid(byte_valid), .byte_rs(byte_rs),
    .byte_data(byte_data), .ddram_addr(ddram_addr), .err_timing(err_timing),
    .err_busy(err_busy), .err_read(err_read)
  );

  always #10 clk = ~clk;

  // count byte_valid pulses away from the active edge
  always @(negedge clk) if (byte_valid) bv_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one E strobe: setup 2 cycles, E high hi_cyc cycles, then lo_cyc cycles low
  task automatic strobe(input logic [3:0] d, input logic rs, input logic rw,
                        input int hi_cyc, input int lo_cyc);
    @(negedge clk);
    bus.SF_D = d; bus.LCD_RS = rs; bus.LCD_RW = rw;
    idle(2);
    bus.LCD_E = 1'b1;
    idle(hi_cyc);
    bus.LCD_E = 1'b0;
    idle(lo_cyc);
    bus.LCD_RW = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b, input logic rs, input int lo_after);
    strobe(b[7:4], rs, 1'b0, 15, 60);
    strobe(b[3:0], rs, 1'b0, 15, lo_after);
  endtask

  task automatic do_init();
    strobe(4'h3, 1'b0, 1'b0, 15, 300);
    strobe(4'h3, 1'b0, 1'b0, 15, 300);
    strobe(4'h3, 1'b0, 1'b0, 15, 300);
    chk("init_pending", init_done, 0);
    strobe(4'h2, 1'b0, 1'b0, 15, 2100);
    chk("init_done", init_done, 1);
  endtask

  initial begin
    int lat;
    int base;
    bus.SF_D = '0; bus.LCD_E = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0;
    idle(3);
    chk("reset_outs", {init_done, byte_valid, byte_rs, byte_data, ddram_addr,
                       err_timing, err_busy, err_read}, 0);
    rst_n = 1'b1;
    idle(3);

    // 1: init sequence
    do_init();
    chk("init_errs", {err_timing, err_busy, err_read}, 0);

    // 2: cmd 0x28 then data 0x41, with a latency measurement on the last fall
    base = bv_cnt;
    wr(8'h28, 1'b0, 2100);
    chk("b0_data", byte_data, 8'h28);
    chk("b0_rs", byte_rs, 0);
    chk("b0_addr", ddram_addr, 0);
    strobe(4'h4, 1'b1, 1'b0, 15, 60);
    @(negedge clk);
    bus.SF_D = 4'h1; idle(2);
    bus.LCD_E = 1'b1; idle(15);
    bus.LCD_E = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (byte_valid) begin lat = k; break; end
    end
    chk("latency", lat, 4);
    idle(2100);
    chk("b1_data", byte_data, 8'h41);
    chk("b1_rs", byte_rs, 1);
    chk("b1_addr", ddram_addr, 1);
    chk("bv_count2", bv_cnt - base, 2);
    chk("t2_errs", {err_timing, err_busy, err_read}, 0);

    // 3: clear with enough busy time, then too little
    wr(8'h01, 1'b0, 8300);
    chk("clr_addr", ddram_addr, 0);
    wr(8'h06, 1'b0, 2100);
    chk("busy_ok", err_busy, 0);
    wr(8'h01, 1'b0, 5000);
    wr(8'h06, 1'b0, 2100);
    chk("busy_err", err_busy, 1);
    chk("busy_addr", ddram_addr, 0);

    // 4: address wrap points
    wr(8'hA7, 1'b0, 2100);
    chk("addr_27", ddram_addr, 7'h27);
    wr(8'h58, 1'b1, 2100);
    chk("wrap_40", ddram_addr, 7'h40);
    wr(8'hE7, 1'b0, 2100);
    chk("addr_67", ddram_addr, 7'h67);
    wr(8'h59, 1'b1, 2100);
    chk("wrap_00", ddram_addr, 7'h00);
    chk("t4_tim", err_timing, 0);

    // 5: short E pulse still accepted; read strobe ignored
    base = bv_cnt;
    strobe(4'h8, 1'b0, 1'b0, 8, 60);
    strobe(4'h5, 1'b0, 1'b0, 15, 2100);
    chk("short_e_err", err_timing, 1);
    chk("short_e_byte", byte_data, 8'h85);
    chk("short_e_addr", ddram_addr, 7'h05);
    chk("read_pre", err_read, 0);
    strobe(4'h3, 1'b0, 1'b1, 15, 2100);
    chk("read_err", err_read, 1);
    wr(8'h41, 1'b1, 2100);
    chk("read_ign_byte", byte_data, 8'h41);
    chk("read_ign_addr", ddram_addr, 7'h06);
    chk("bv_count5", bv_cnt - base, 2);

    // 6: reset between upper and lower nibble, then clean re-init
    strobe(4'h7, 1'b1, 1'b0, 15, 60);
    @(negedge clk); rst_n = 1'b0;
    idle(3);
    chk("mid_reset_outs", {init_done, byte_valid, byte_rs, byte_data, ddram_addr,
                           err_timing, err_busy, err_read}, 0);
    rst_n = 1'b1;
    idle(3);
    do_init();
    wr(8'h42, 1'b1, 2100);
    chk("reinit_byte", byte_data, 8'h42);
    chk("reinit_addr", ddram_addr, 1);
    chk("reinit_errs", {err_timing, err_busy, err_read}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
